// File: rtl/hz_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the frequency meter.
// One shift per clock, leading-zero blanking, start/busy/done handshake.
module hz_bcd_converter #(
  parameter int WIDTH      = 28,
  parameter int DIGITS     = 9,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_a_n,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   den_q, den_d;

  logic [BW-1:0]       adj;
  logic [DIGITS-1:0]   den_calc;
  logic                nz;
  logic                trig;

  assign trig = start | (AUTO_START && (bin_in != last_q));

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // A digit is lit if it or any more significant digit is nonzero.
  always_comb begin
    nz       = 1'b0;
    den_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz          = nz | (|scr_q[4*i +: 4]);
      den_calc[i] = nz;
    end
    den_calc[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    last_d  = last_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    den_d   = den_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          bin_d   = bin_in;
          last_d  = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = scr_q;
        den_d   = den_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      last_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      den_q   <= DIGITS'(1);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      last_q  <= last_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      den_q   <= den_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign digit_en = den_q;

endmodule

// File: tb/tb_hz_bcd_converter.sv
// Directed bench for hz_bcd_converter: one auto-start and one
// manual-start instance sharing clock and reset.
module tb_hz_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] bin_a = 28'd1200;
  logic [27:0] bin_m = 28'd0;
  logic        start_a = 1'b0;
  logic        start_m = 1'b0;
  logic        busy_a, done_a, busy_m, done_m;
  logic [35:0] bcd_a, bcd_m;
  logic [8:0]  den_a, den_m;

  int npass = 0;
  int ntot  = 0;
  int nd_a  = 0;
  int nd_m  = 0;
  int n;
  int base;

  always #5 clk = ~clk;

  hz_bcd_converter #(.WIDTH(28), .DIGITS(9), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst_a_n(rst_n), .bin_in(bin_a), .start(start_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .digit_en(den_a)
  );

  hz_bcd_converter #(.WIDTH(28), .DIGITS(9), .AUTO_START(1'b0)) dut_m (
    .clk(clk), .rst_a_n(rst_n), .bin_in(bin_m), .start(start_m),
    .busy(busy_m), .done(done_m), .bcd(bcd_m), .digit_en(den_m)
  );

  always @(posedge clk) begin
    if (done_a) nd_a <= nd_a + 1;
    if (done_m) nd_m <= nd_m + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Counts negedges until done is seen; gives up after 100.
  task automatic wait_done(input bit auto, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(auto ? done_a : done_m) && cyc < 100);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_bcd_a", bcd_a, 0);
    chk("rst_den_a", den_a, 9'h001);
    chk("rst_den_m", den_m, 9'h001);

    // 1: auto trigger after release with bin_in=1200
    rst_n = 1'b1;
    #1 chk("rel_busy0", busy_a, 0);
    @(negedge clk);
    chk("rel_busy1", busy_a, 1);
    wait_done(1'b1, n);
    chk("t1_lat", n, 29);
    chk("t1_bcd", bcd_a, 36'h000001200);
    chk("t1_den", den_a, 9'b000001111);
    @(negedge clk);
    chk("t1_done_1cyc", done_a, 0);
    chk("t1_busy_idle", busy_a, 0);
    chk("t1_hold", bcd_a, 36'h000001200);

    // 2: manual all-ones
    bin_m = 28'hFFFFFFF;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("t2_busy", busy_m, 1);
    wait_done(1'b0, n);
    chk("t2_lat", n, 29);
    chk("t2_bcd", bcd_m, 36'h268435455);
    chk("t2_den", den_m, 9'h1FF);
    @(negedge clk);
    chk("t2_done_1cyc", done_m, 0);

    // 3: manual zero
    bin_m = 28'd0;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_done(1'b0, n);
    chk("t3_lat", n, 29);
    chk("t3_bcd", bcd_m, 0);
    chk("t3_den", den_m, 9'b000000001);

    // 4: change mid-conversion is picked up afterwards
    bin_a = 28'd7;
    wait_done(1'b1, n);
    chk("t4_pre", bcd_a, 36'h7);
    chk("t4_pre_den", den_a, 9'b000000001);
    repeat (2) @(negedge clk);
    base = nd_a;
    bin_a = 28'd1200;
    @(negedge clk);
    chk("t4_busy", busy_a, 1);
    repeat (9) @(negedge clk);
    bin_a = 28'd50000;
    wait_done(1'b1, n);
    chk("t4_lat1", n, 20);
    chk("t4_bcd1", bcd_a, 36'h000001200);
    wait_done(1'b1, n);
    chk("t4_lat2", n, 30);
    chk("t4_bcd2", bcd_a, 36'h000050000);
    chk("t4_den2", den_a, 9'b000011111);
    repeat (4) @(negedge clk);
    chk("t4_ndone", nd_a - base, 2);

    // 5: start held every cycle while busy, bin_in changed mid-way
    base = nd_m;
    bin_m = 28'd12345678;
    start_m = 1'b1;
    @(negedge clk);
    bin_m = 28'd999;
    wait_done(1'b0, n);
    start_m = 1'b0;
    chk("t5_lat", n, 29);
    chk("t5_bcd", bcd_m, 36'h012345678);
    chk("t5_den", den_m, 9'b011111111);
    repeat (5) @(negedge clk);
    chk("t5_ndone", nd_m - base, 1);
    chk("t5_hold", bcd_m, 36'h012345678);

    // 6: asynchronous reset mid-shift
    base = nd_a;
    bin_a = 28'd4321;
    @(negedge clk);
    chk("t6_busy", busy_a, 1);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_clr", busy_a, 0);
    chk("t6_done_clr", done_a, 0);
    chk("t6_bcd_clr", bcd_a, 0);
    chk("t6_den_clr", den_a, 9'h001);
    chk("t6_bcd_m_clr", bcd_m, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", nd_a - base, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_retrig", busy_a, 1);
    wait_done(1'b1, n);
    chk("t6_lat", n, 29);
    chk("t6_bcd", bcd_a, 36'h000004321);
    chk("t6_den", den_a, 9'b000001111);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
